// File: rtl/xor_reduce_serial_if.sv
// Stream bundle for xor_reduce_serial: the word input channel and the packet result channel.
`timescale 1ns/1ps
interface xor_reduce_serial_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_odd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, in_odd, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, in_odd, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_count
    );
endinterface

// File: rtl/xor_reduce_serial.sv
// Per-packet XOR reduction of a word stream: word XOR, parity folded STEP bits per cycle,
// and a saturating word count, returned over a valid/ready result channel.
`timescale 1ns/1ps
module xor_reduce_serial #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    xor_reduce_serial_if.slave bus
);
    localparam int SLICES = WIDTH / STEP;
    localparam int SC_W   = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shift_reg;
    logic [SC_W-1:0]  slice_cnt;
    logic [CNT_W-1:0] cnt;
    logic             par;
    logic             last_reg;
    logic             odd_reg;
    logic             accept;
    logic             slice_done;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign slice_done = (slice_cnt == SC_W'(SLICES - 1));

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (slice_done)   state_next = last_reg ? DONE : IDLE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            shift_reg <= '0;
            slice_cnt <= '0;
            cnt       <= '0;
            par       <= 1'b0;
            last_reg  <= 1'b0;
            odd_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc       <= acc ^ bus.in_data;
                    shift_reg <= bus.in_data;
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    last_reg  <= bus.in_last;
                    odd_reg   <= bus.in_odd;
                    slice_cnt <= '0;
                end
                SHIFT: begin
                    // Low slice folds into parity while the register walks down by STEP.
                    par       <= par ^ (^shift_reg[STEP-1:0]);
                    shift_reg <= shift_reg >> STEP;
                    slice_cnt <= slice_cnt + 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    acc <= '0;
                    par <= 1'b0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_data   = acc;
    assign bus.out_parity = par ^ odd_reg;
    assign bus.out_count  = cnt;
endmodule

// File: tb/tb_xor_reduce_serial.sv
// Scoreboard bench for xor_reduce_serial: three instances cover the default build,
// a 2-bit saturating counter, and a single-slice (STEP==WIDTH) build.
`timescale 1ns/1ps
module tb_xor_reduce_serial;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor_reduce_serial_if #(.WIDTH(16), .CNT_W(8)) bus_a ();
    xor_reduce_serial_if #(.WIDTH(16), .CNT_W(2)) bus_b ();
    xor_reduce_serial_if #(.WIDTH(8),  .CNT_W(8)) bus_c ();

    xor_reduce_serial #(.WIDTH(16), .STEP(4), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    xor_reduce_serial #(.WIDTH(16), .STEP(4), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    xor_reduce_serial #(.WIDTH(8),  .STEP(8), .CNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    typedef struct {
        logic [15:0] data;
        logic        parity;
        logic [7:0]  count;
        logic        odd;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t ea, eb, ec;
    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic score(string tag, exp_t e, logic [15:0] d, logic p, logic [7:0] c);
        check({tag, "_data"},      32'(d), 32'(e.data));
        check({tag, "_parity"},    32'(p), 32'(e.parity));
        check({tag, "_count"},     32'(c), 32'(e.count));
        check({tag, "_invariant"}, 32'(p), 32'((^d) ^ e.odd));
    endtask

    task automatic spurious(string tag);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: result presented with empty scoreboard", tag);
    endtask

    // Monitors: compare whenever a result handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) spurious("a");
            else begin
                ea = q_a.pop_front();
                score("a", ea, bus_a.out_data, bus_a.out_parity, bus_a.out_count);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) spurious("b");
            else begin
                eb = q_b.pop_front();
                score("b", eb, bus_b.out_data, bus_b.out_parity, 8'(bus_b.out_count));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_c.out_valid && bus_c.out_ready) begin
            if (q_c.size() == 0) spurious("c");
            else begin
                ec = q_c.pop_front();
                score("c", ec, 16'(bus_c.out_data), bus_c.out_parity, bus_c.out_count);
            end
        end
    end

    function automatic int qsize(int d);
        case (d)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic logic rdy(int d);
        case (d)
            0:       return bus_a.in_ready;
            1:       return bus_b.in_ready;
            default: return bus_c.in_ready;
        endcase
    endfunction

    task automatic push(int d, logic [15:0] data, logic parity, logic [7:0] count, logic odd);
        exp_t e;
        e.data = data; e.parity = parity; e.count = count; e.odd = odd;
        case (d)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic drive(int d, logic v, logic [15:0] data, logic last, logic odd);
        case (d)
            0: begin bus_a.in_valid = v; bus_a.in_data = data;      bus_a.in_last = last; bus_a.in_odd = odd; end
            1: begin bus_b.in_valid = v; bus_b.in_data = data;      bus_b.in_last = last; bus_b.in_odd = odd; end
            default: begin
                bus_c.in_valid = v; bus_c.in_data = data[7:0]; bus_c.in_last = last; bus_c.in_odd = odd;
            end
        endcase
    endtask

    // Returns at 1 time unit after the accepting edge.
    task automatic send(int d, logic [15:0] data, logic last, logic odd);
        int n = 0;
        @(negedge clk);
        drive(d, 1'b1, data, last, odd);
        while (!rdy(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(rdy(d)), 32'd1);
        @(posedge clk);
        #1 drive(d, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic drain(int d, int budget);
        int n = 0;
        while (qsize(d) != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(2, 1'b0, 16'h0000, 1'b0, 1'b0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_c.out_ready = 1'b1;
        #12;
        check("rst_in_ready",   32'(bus_a.in_ready),   32'd1);
        check("rst_out_valid",  32'(bus_a.out_valid),  32'd0);
        check("rst_out_data",   32'(bus_a.out_data),   32'd0);
        check("rst_out_parity", 32'(bus_a.out_parity), 32'd0);
        check("rst_out_count",  32'(bus_a.out_count),  32'd0);
        check("rst_b_ready",    32'(bus_b.in_ready),   32'd1);
        check("rst_c_valid",    32'(bus_c.out_valid),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word: result visible in the cycle after edge 4.
        push(0, 16'hA5A5, 1'b0, 8'd1, 1'b0);
        send(0, 16'hA5A5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat_out_valid_low", 32'(bus_a.out_valid), 32'd0);
            check("lat_in_ready_low",  32'(bus_a.in_ready),  32'd0);
        end
        @(negedge clk);
        check("lat_out_valid_edge4", 32'(bus_a.out_valid), 32'd1);
        drain(0, 20);

        // Three words; the odd flag on the last word governs.
        push(0, 16'h00F2, 1'b0, 8'd3, 1'b1);
        send(0, 16'h0001, 1'b0, 1'b0);
        send(0, 16'h0003, 1'b0, 1'b0);
        send(0, 16'h00F0, 1'b1, 1'b1);
        drain(0, 30);

        // Same packet with the consumer stalled for 10 cycles.
        bus_a.out_ready = 1'b0;
        push(0, 16'h00F2, 1'b0, 8'd3, 1'b1);
        send(0, 16'h0001, 1'b0, 1'b0);
        send(0, 16'h0003, 1'b0, 1'b0);
        send(0, 16'h00F0, 1'b1, 1'b1);
        n = 0;
        while (!bus_a.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", 32'(bus_a.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid",  32'(bus_a.out_valid),  32'd1);
            check("stall_ready",  32'(bus_a.in_ready),   32'd0);
            check("stall_data",   32'(bus_a.out_data),   32'h00F2);
            check("stall_parity", 32'(bus_a.out_parity), 32'd0);
            check("stall_count",  32'(bus_a.out_count),  32'd3);
            @(posedge clk);
            #1 drive(0, (i % 2 == 0) && (i < 9), 16'hFFFF, 1'b1, 1'b1);
        end
        drive(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus_a.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_valid", 32'(bus_a.out_valid), 32'd0);
        check("post_hs_ready", 32'(bus_a.in_ready),  32'd1);
        check("post_hs_data",  32'(bus_a.out_data),  32'd0);
        check("post_hs_count", 32'(bus_a.out_count), 32'd0);
        push(0, 16'h0010, 1'b1, 8'd1, 1'b0);
        send(0, 16'h0010, 1'b1, 1'b0);
        drain(0, 20);

        // Asynchronous reset in the middle of a second word's shift.
        send(0, 16'h1111, 1'b0, 1'b0);
        send(0, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus_a.in_ready),  32'd1);
        check("arst_out_data",  32'(bus_a.out_data),  32'd0);
        check("arst_out_count", 32'(bus_a.out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(0, 16'h0007, 1'b1, 8'd1, 1'b0);
        send(0, 16'h0007, 1'b1, 1'b0);
        drain(0, 20);

        // All-zero packet in odd mode.
        push(0, 16'h0000, 1'b1, 8'd2, 1'b1);
        send(0, 16'h0000, 1'b0, 1'b1);
        send(0, 16'h0000, 1'b1, 1'b1);
        drain(0, 20);

        // Counter saturates at 3 with CNT_W=2.
        push(1, 16'h0001, 1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) send(1, 16'h0001, i == 4, 1'b0);
        drain(1, 20);

        // STEP==WIDTH: result visible in the cycle after edge 1.
        push(2, 16'h00FF, 1'b0, 8'd1, 1'b0);
        send(2, 16'h00FF, 1'b1, 1'b0);
        @(negedge clk);
        check("c_lat_valid_low", 32'(bus_c.out_valid), 32'd0);
        check("c_lat_ready_low", 32'(bus_c.in_ready),  32'd0);
        @(negedge clk);
        check("c_lat_valid_edge1", 32'(bus_c.out_valid), 32'd1);
        drain(2, 20);
        push(2, 16'h0080, 1'b0, 8'd1, 1'b1);
        send(2, 16'h0080, 1'b1, 1'b1);
        drain(2, 20);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xor_reduce_serial.md
Name: xor_reduce_serial

Overview:
- Parametrised successor to the single-bit mux-built XOR gate.
- Accepts a packet of WIDTH-bit words over a valid/ready stream.
- Produces three per-packet results: the bitwise XOR of all words, the packet parity (even or odd mode), and a word count.
- Folds parity STEP bits per cycle through a small shift datapath, trading latency for area. Sits between a word source and a checksum/parity consumer.

Parameters:
- WIDTH, 16: data word width in bits.
- STEP, 4: bits folded into parity per cycle. Must divide WIDTH; STEP==WIDTH is legal.
- CNT_W, 8: width of the saturating word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  word is the last of its packet.
- in_odd  input  1  parity mode, sampled with each accepted word; the value on the last word governs (1 = odd parity, output inverted).
- out_valid  output  1  packet result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  XOR of all words in the packet.
- out_parity  output  1  XOR-reduction of all packet bits, XORed with the latched in_odd.
- out_count  output  CNT_W  words in the packet, saturating.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset: state=IDLE, acc=0, par=0, cnt=0, slice counter=0, shift reg=0, last_reg=0, odd_reg=0.
- Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_parity=0, out_count=0.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from state only, with no combinational path from inputs.
- IDLE, when in_valid&&in_ready:
  - acc <= acc ^ in_data; shift reg <= in_data.
  - cnt <= cnt+1, holding at 2^CNT_W-1.
  - last_reg <= in_last; odd_reg <= in_odd; slice counter <= 0; go to SHIFT.
- SHIFT, each cycle:
  - par <= par ^ (XOR of shift reg[STEP-1:0]); shift reg >>= STEP; slice counter++.
  - On the slice counter reaching WIDTH/STEP-1: go to DONE if last_reg, else IDLE.
  - in_valid is ignored in SHIFT and DONE; the upstream holds its data under the handshake.
- DONE: out_data=acc, out_parity=par^odd_reg, out_count=cnt, all held stable while out_ready=0.
  - On out_ready: acc, par and cnt clear to 0; go to IDLE.
- Latency:
  - Word accepted at edge 0; SHIFT occupies edges 1..WIDTH/STEP.
  - For a last word, out_valid is high in the cycle after edge WIDTH/STEP.
  - Non-last words: in_ready returns in the same cycle position. Throughput is one word per WIDTH/STEP+1 cycles.
- Result invariant: the parity output equals XOR-reduction(out_data)^odd_reg; the verifier checks this every packet.
- The parity path is built from the team's 2:1 mux XOR cell or a plain operator, implementer's choice. Behaviour is identical either way.
- Reset mid-operation: asynchronous and immediate. Any partial packet is discarded, and the next accepted word starts a fresh packet.
- Single-word packet is legal (in_last on the first word, count=1).
- Packet of all-zero words: out_data=0, out_parity=odd_reg.

Test Plan:
- WIDTH=16, STEP=4: single word 16'hA5A5, last=1, odd=0 → out_valid in the cycle after edge 4; out_data=16'hA5A5, out_parity=0, out_count=1; in_ready=0 from edge 1 until out_ready.
- Three words 16'h0001, 16'h0003, 16'h00F0 (last on third, odd=1) → out_data=16'h00F2 (5 ones), out_parity=0, out_count=3.
- Same packet with out_ready held low 10 cycles after out_valid → outputs stable, in_ready=0, in_valid pulses ignored. On out_ready: one-cycle handshake, state IDLE, next packet starts from acc=0.
- Assert rst asynchronously mid-SHIFT of a second word → out_valid=0 and in_ready=1 immediately. A following single word 16'h0007 (odd=0) → out_data=16'h0007, out_parity=1, out_count=1.
- CNT_W=2: five-word packet of 16'h0001 → out_count=3 (saturated), out_data=16'h0001, out_parity=1.
- WIDTH=8, STEP=8: word 8'hFF, last=1, odd=0 → out_valid in the cycle after edge 1; out_parity=0. Word 8'h80, odd=1 → out_parity=0.
